// File: rtl/id_pipe.sv
// Instruction-decode pipeline stage: register file with write-through bypass,
// operand/immediate decode, load-use hazard detection and a valid/ready output register.
module id_pipe #(
  parameter int DW          = 32,
  parameter int AW          = 5,
  parameter int LINK_REG    = 31,
  parameter int REGDST_BIT  = 0,
  parameter int JAL_BIT     = 13,
  parameter int MEMREAD_BIT = 14,
  parameter int ZEXT_BIT    = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_pc,
  input  logic [31:0]   in_ir,
  input  logic [31:0]   in_signal,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_rw,
  input  logic [DW-1:0] wb_din,
  input  logic          flush,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_pc,
  output logic [31:0]   out_ir,
  output logic [31:0]   out_signal,
  output logic [AW-1:0] dst,
  output logic [AW-1:0] r1_pos,
  output logic [AW-1:0] r2_pos,
  output logic [DW-1:0] ext,
  output logic [DW-1:0] r1,
  output logic [DW-1:0] r2,
  output logic [DW-1:0] v0,
  output logic [DW-1:0] a0
);

  localparam int              NREG     = 1 << AW;
  localparam logic [AW-1:0]   LINK_IDX = AW'(LINK_REG);
  localparam logic [AW-1:0]   V0_IDX   = AW'(2);
  localparam logic [AW-1:0]   A0_IDX   = AW'(4);

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic [DW-1:0] rf_q [NREG];
  logic          wr_en;

  assign wr_en = wb_we && !rst && (wb_rw != '0);

  // NOTE: the file must come out of reset all-zero, so it is built from resettable
  // flops rather than a RAM macro; entry 0 is never written and stays zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (wr_en) begin
      rf_q[wb_rw] <= wb_din;
    end
  end

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic [AW-1:0] src1, src2, dec_dst;
  logic [DW-1:0] dec_ext, rd1, rd2;

  assign src1 = AW'(in_ir[25:21]);
  assign src2 = AW'(in_ir[20:16]);

  assign dec_dst = in_signal[JAL_BIT]    ? LINK_IDX            :
                   in_signal[REGDST_BIT] ? AW'(in_ir[15:11])   :
                                           src2;

  assign dec_ext = in_signal[ZEXT_BIT] ? DW'(in_ir[15:0]) : DW'($signed(in_ir[15:0]));

  // A read of the address being written this cycle sees the incoming data.
  assign rd1 = (src1 == '0) ? '0 : (wr_en && wb_rw == src1)   ? wb_din : rf_q[src1];
  assign rd2 = (src2 == '0) ? '0 : (wr_en && wb_rw == src2)   ? wb_din : rf_q[src2];
  assign v0  =                     (wr_en && wb_rw == V0_IDX) ? wb_din : rf_q[V0_IDX];
  assign a0  =                     (wr_en && wb_rw == A0_IDX) ? wb_din : rf_q[A0_IDX];

  // ---------------------------------------------------------------------------
  // Output register and handshake
  // ---------------------------------------------------------------------------
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_pc_q, out_pc_d;
  logic [31:0]   out_ir_q, out_ir_d;
  logic [31:0]   out_signal_q, out_signal_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [AW-1:0] r1_pos_q, r1_pos_d;
  logic [AW-1:0] r2_pos_q, r2_pos_d;
  logic [DW-1:0] ext_q, ext_d;
  logic [DW-1:0] r1_q, r1_d;
  logic [DW-1:0] r2_q, r2_d;
  logic          hazard, accept;

  // A load still sitting in the output register cannot forward its data yet.
  assign hazard = out_valid_q && out_signal_q[MEMREAD_BIT] && (dst_q != '0) &&
                  ((dst_q == src1) || (dst_q == src2));

  assign in_ready = !rst && !flush && !hazard && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // NOTE: every always_comb output is given its hold value first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_pc_d     = out_pc_q;
    out_ir_d     = out_ir_q;
    out_signal_d = out_signal_q;
    dst_d        = dst_q;
    r1_pos_d     = r1_pos_q;
    r2_pos_d     = r2_pos_q;
    ext_d        = ext_q;
    r1_d         = r1_q;
    r2_d         = r2_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d  = 1'b1;
      out_pc_d     = in_pc;
      out_ir_d     = in_ir;
      out_signal_d = in_signal;
      dst_d        = dec_dst;
      r1_pos_d     = src1;
      r2_pos_d     = src2;
      ext_d        = dec_ext;
      r1_d         = rd1;
      r2_d         = rd2;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments so all
  // registers sample their next-state values from the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_pc_q     <= '0;
      out_ir_q     <= '0;
      out_signal_q <= '0;
      dst_q        <= '0;
      r1_pos_q     <= '0;
      r2_pos_q     <= '0;
      ext_q        <= '0;
      r1_q         <= '0;
      r2_q         <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_pc_q     <= out_pc_d;
      out_ir_q     <= out_ir_d;
      out_signal_q <= out_signal_d;
      dst_q        <= dst_d;
      r1_pos_q     <= r1_pos_d;
      r2_pos_q     <= r2_pos_d;
      ext_q        <= ext_d;
      r1_q         <= r1_d;
      r2_q         <= r2_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_pc     = out_pc_q;
  assign out_ir     = out_ir_q;
  assign out_signal = out_signal_q;
  assign dst        = dst_q;
  assign r1_pos     = r1_pos_q;
  assign r2_pos     = r2_pos_q;
  assign ext        = ext_q;
  assign r1         = r1_q;
  assign r2         = r2_q;

endmodule

// File: tb/tb_id_pipe.sv
// Self-checking bench for id_pipe: decode vector table, hand-written handshake
// corner cases and a random stretch, all compared against a one-entry scoreboard.
module tb_id_pipe;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam logic [31:0] S_REGDST  = 32'h0000_0001;
  localparam logic [31:0] S_JAL     = 32'h0000_2000;
  localparam logic [31:0] S_MEMREAD = 32'h0000_4000;
  localparam logic [31:0] S_ZEXT    = 32'h0000_8000;

  logic          clk, rst, in_valid, in_ready, wb_we, flush, out_ready, out_valid;
  logic [DW-1:0] in_pc, wb_din, out_pc, ext, r1, r2, v0, a0;
  logic [31:0]   in_ir, in_signal, out_ir, out_signal;
  logic [AW-1:0] wb_rw, dst, r1_pos, r2_pos;

  id_pipe #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_ir(in_ir), .in_signal(in_signal),
    .wb_we(wb_we), .wb_rw(wb_rw), .wb_din(wb_din),
    .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
    .out_pc(out_pc), .out_ir(out_ir), .out_signal(out_signal),
    .dst(dst), .r1_pos(r1_pos), .r2_pos(r2_pos),
    .ext(ext), .r1(r1), .r2(r2), .v0(v0), .a0(a0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc, ir, sig;
    logic [4:0]  dst, r1p, r2p;
    logic [31:0] ext, r1, r2;
  } rec_t;

  typedef struct {
    logic        we;
    logic [4:0]  rw;
    logic [31:0] din;
    logic [4:0]  rs, rt;
    logic [15:0] imm;
    logic [31:0] sig;
    logic [4:0]  e_dst;
    logic [31:0] e_ext, e_r1;
  } vec_t;

  rec_t        exp_q[$];
  logic [31:0] rf_m [32];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] pc_ctr = 32'h0000_1000;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_ir(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [15:0] imm);
    return {6'h23, rs, rt, imm};
  endfunction

  task automatic drive(input logic v, input logic [31:0] ir, input logic [31:0] sig);
    in_valid  = v;
    in_ir     = ir;
    in_signal = sig;
    pc_ctr    = pc_ctr + 32'd4;
    in_pc     = pc_ctr;
  endtask

  task automatic idle();
    rst = 1'b0; in_valid = 1'b0; wb_we = 1'b0; flush = 1'b0; out_ready = 1'b1;
  endtask

  function automatic logic model_ready();
    logic haz;
    if (rst) return 1'b0;
    haz = (exp_q.size() != 0) && exp_q[0].sig[14] && (exp_q[0].dst != 5'd0) &&
          ((exp_q[0].dst == in_ir[25:21]) || (exp_q[0].dst == in_ir[20:16]));
    return !flush && !haz && ((exp_q.size() == 0) || out_ready);
  endfunction

  // Built after the writeback of this cycle is folded into rf_m, which is what a
  // write-through register file returns.
  function automatic rec_t model_rec();
    rec_t r;
    r.pc  = in_pc;
    r.ir  = in_ir;
    r.sig = in_signal;
    r.r1p = in_ir[25:21];
    r.r2p = in_ir[20:16];
    r.dst = in_signal[13] ? 5'd31 : (in_signal[0] ? in_ir[15:11] : in_ir[20:16]);
    r.ext = in_signal[15] ? {16'h0000, in_ir[15:0]} : {{16{in_ir[15]}}, in_ir[15:0]};
    r.r1  = rf_m[in_ir[25:21]];
    r.r2  = rf_m[in_ir[20:16]];
    return r;
  endfunction

  // One clock: check combinational outputs, advance the model, then check the
  // registered outputs on the following falling edge.
  task automatic tick();
    logic rdy;
    rec_t act;
    #1;
    rdy = model_ready();
    check("in_ready", in_ready, rdy);
    if (rst) begin
      exp_q.delete();
      for (int i = 0; i < 32; i++) rf_m[i] = '0;
    end else begin
      if (wb_we && wb_rw != 5'd0) rf_m[wb_rw] = wb_din;
      check("v0", v0, rf_m[2]);
      check("a0", a0, rf_m[4]);
      if (flush) exp_q.delete();
      else if (in_valid && rdy) begin
        exp_q.delete();
        exp_q.push_back(model_rec());
      end else if (out_ready) exp_q.delete();
    end
    @(posedge clk);
    @(negedge clk);
    check("out_valid", out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      act = {out_pc, out_ir, out_signal, dst, r1_pos, r2_pos, ext, r1, r2};
      check("out_rec", act, exp_q[0]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[7];
    logic [31:0] held_ir, held_pc, held_ext, held_r1, y_ir, z_ir;

    tbl[0] = '{1'b1, 5'd5, 32'h0000_1234, 5'd5, 5'd0, 16'h0000, 32'h0,
               5'd0,  32'h0000_0000, 32'h0000_1234};
    tbl[1] = '{1'b1, 5'd1, 32'hA5A5_0001, 5'd1, 5'd5, 16'h1800, S_REGDST,
               5'd3,  32'h0000_1800, 32'hA5A5_0001};
    tbl[2] = '{1'b0, 5'd0, 32'h0,         5'd5, 5'd7, 16'hFFFF, 32'h0,
               5'd7,  32'hFFFF_FFFF, 32'h0000_1234};
    tbl[3] = '{1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 16'hFFFF, S_ZEXT,
               5'd0,  32'h0000_FFFF, 32'h0000_0000};
    tbl[4] = '{1'b0, 5'd0, 32'h0,         5'd0, 5'd0, 16'h8000, S_JAL | S_REGDST,
               5'd31, 32'hFFFF_8000, 32'h0000_0000};
    tbl[5] = '{1'b0, 5'd0, 32'h0,         5'd1, 5'd0, 16'h8000, S_JAL | S_REGDST | S_ZEXT,
               5'd31, 32'h0000_8000, 32'hA5A5_0001};
    tbl[6] = '{1'b1, 5'd2, 32'h0000_CAFE, 5'd2, 5'd4, 16'h7C00, S_REGDST,
               5'd15, 32'h0000_7C00, 32'h0000_CAFE};

    // Reset, with an instruction offered that must be refused.
    idle();
    wb_rw = '0; wb_din = '0;
    rst = 1'b1;
    drive(1'b1, mk_ir(5'd3, 5'd4, 16'h1111), 32'h0);
    tick();
    tick();
    idle();
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_ext", ext, 32'h0);
    check("rst_r1", r1, 32'h0);
    check("rst_dst", dst, 5'd0);

    // Decode table, issued back to back.
    for (int i = 0; i < 7; i++) begin
      wb_we = tbl[i].we; wb_rw = tbl[i].rw; wb_din = tbl[i].din;
      drive(1'b1, mk_ir(tbl[i].rs, tbl[i].rt, tbl[i].imm), tbl[i].sig);
      tick();
      check($sformatf("tbl%0d_dst", i), dst, tbl[i].e_dst);
      check($sformatf("tbl%0d_ext", i), ext, tbl[i].e_ext);
      check($sformatf("tbl%0d_r1", i), r1, tbl[i].e_r1);
    end
    idle();
    tick();

    // Load-use hazard: exactly one bubble.
    drive(1'b1, mk_ir(5'd0, 5'd8, 16'h0000), S_MEMREAD);
    tick();
    drive(1'b1, mk_ir(5'd1, 5'd8, 16'h0010), 32'h0);
    #1 check("haz_ready", in_ready, 1'b0);
    tick();
    check("haz_bubble", out_valid, 1'b0);
    tick();
    check("haz_accept_valid", out_valid, 1'b1);
    check("haz_accept_ir", out_ir, mk_ir(5'd1, 5'd8, 16'h0010));

    // Backpressure for three cycles, then the next instruction with no gap.
    held_ir = out_ir; held_pc = out_pc; held_ext = ext; held_r1 = r1;
    y_ir = mk_ir(5'd2, 5'd3, 16'h0042);
    out_ready = 1'b0;
    drive(1'b1, y_ir, 32'h0);
    for (int k = 0; k < 3; k++) begin
      #1 check("bp_ready", in_ready, 1'b0);
      tick();
      check("bp_hold", {out_pc, out_ir, ext, r1}, {held_pc, held_ir, held_ext, held_r1});
    end
    out_ready = 1'b1;
    tick();
    check("bp_next_valid", out_valid, 1'b1);
    check("bp_next_ir", out_ir, y_ir);

    // Flush with a stalled output and an incoming instruction; writeback proceeds.
    z_ir = mk_ir(5'd4, 5'd5, 16'h0077);
    out_ready = 1'b0;
    drive(1'b1, z_ir, 32'h0);
    flush = 1'b1; wb_we = 1'b1; wb_rw = 5'd4; wb_din = 32'hBEEF_0004;
    #1 check("flush_ready", in_ready, 1'b0);
    check("flush_a0_bypass", a0, 32'hBEEF_0004);
    tick();
    check("flush_valid", out_valid, 1'b0);
    idle();
    #1 check("flush_a0", a0, 32'hBEEF_0004);
    tick();
    check("flush_no_capture", out_valid, 1'b0);

    // Reset mid-stream discards the held instruction and the writeback.
    drive(1'b1, mk_ir(5'd2, 5'd4, 16'h0005), 32'h0);
    tick();
    rst = 1'b1; out_ready = 1'b0; wb_we = 1'b1; wb_rw = 5'd4; wb_din = 32'h5555_5555;
    drive(1'b1, mk_ir(5'd6, 5'd7, 16'h0006), 32'h0);
    #1 check("rst_mid_ready", in_ready, 1'b0);
    tick();
    idle();
    #1 check("rst_mid_valid", out_valid, 1'b0);
    check("rst_mid_v0", v0, 32'h0);
    check("rst_mid_a0", a0, 32'h0);
    tick();

    // Random traffic against the scoreboard.
    for (int n = 0; n < 300; n++) begin
      wb_we     = ($urandom_range(0, 2) == 0);
      wb_rw     = 5'($urandom_range(0, 7));
      wb_din    = $urandom;
      flush     = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      drive(($urandom_range(0, 3) != 0),
            mk_ir(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)),
            $urandom & (S_REGDST | S_JAL | S_MEMREAD | S_ZEXT | 32'h0000_0F00));
      tick();
    end
    idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
